// File: rtl/nack_gen_pkg.sv
// Shared types and helpers for the NACK generator FIFO write arbiter.
package nack_gen_pkg;

    // Arbiter FSM: wait out FIFO reset, arbitrate, then stream one packet.
    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        LOCK = 2'd2
    } arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               gnt_vld
);

    // Scan ptr, ptr+1, ... wrapping modulo NUM_REQ; lowest distance wins.
    always_comb begin
        logic [IDX_W:0] v_sum;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        v_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr < NUM_REQ and i < NUM_REQ, so one subtraction wraps it.
            v_sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (v_sum >= (IDX_W+1)'(NUM_REQ)) begin
                v_sum = v_sum - (IDX_W+1)'(NUM_REQ);
            end
            if (!gnt_vld && req[v_sum[IDX_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = v_sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/nack_fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one sync FIFO write port
// between NUM_REQ NACK requesters. Registers the FIFO write strobe/data
// and keeps packet, beat and overflow statistics. Single clock: wr_clk.
//
// Handshake: a beat moves when req_valid[i] and req_ready[i] are both high
// at a rising edge of wr_clk. req_ready is one-hot (current grantee) or
// zero, and does not depend on req_valid. A requester may drop valid
// mid-packet; the grant is held until the beat with req_last is accepted.
module nack_fifo_wr_arbiter
    import nack_gen_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int CNT_WIDTH  = 32,
    localparam int IDX_W      = idx_width(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    input  logic                          fifo_prog_full,
    input  logic                          fifo_wr_rst_busy,
    input  logic                          fifo_overflow,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          pkt_cnt,
    output logic [CNT_WIDTH-1:0]          beat_cnt,
    output logic                          err_overflow,
    output logic [1:0]                    dbg_state
);

    arb_state_t            r_state;
    logic [IDX_W-1:0]      r_grant_id;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_din;
    logic [CNT_WIDTH-1:0]  r_pkt_cnt;
    logic [CNT_WIDTH-1:0]  r_beat_cnt;
    logic                  r_err_overflow;

    logic [IDX_W-1:0]      w_gnt_id;
    logic                  w_gnt_vld;
    logic                  w_can_write;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_accept;
    logic                  w_last_accept;
    logic [IDX_W-1:0]      w_next_ptr;
    logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

    // Split the flat data bus into one beat per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_data_split
        assign w_data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .gnt_id  (w_gnt_id),
        .gnt_vld (w_gnt_vld)
    );

    // almost_full gates every beat; the registered write strobe lands one
    // cycle later, so stopping here keeps writes off a full FIFO.
    assign w_can_write   = (r_state == LOCK) && !fifo_full && !fifo_almost_full
                           && !fifo_wr_rst_busy;
    assign w_sel_valid   = req_valid[r_grant_id];
    assign w_sel_last    = req_last[r_grant_id];
    assign w_sel_data    = w_data_arr[r_grant_id];
    assign w_accept      = w_can_write && w_sel_valid;
    assign w_last_accept = w_accept && w_sel_last;
    assign w_next_ptr    = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0
                                                                : r_grant_id + 1'b1;

    // Only the grantee sees ready; everyone else is held off.
    always_comb begin
        req_ready             = '0;
        req_ready[r_grant_id] = w_can_write;
    end

    // FSM: leave INIT once the FIFO is out of reset, lock onto a winner,
    // release on the accepted last beat and advance the round-robin pointer.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            r_state    <= INIT;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    if (!fifo_wr_rst_busy) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    // prog_full only holds off the start of a packet.
                    if (w_gnt_vld && !fifo_prog_full) begin
                        r_state    <= LOCK;
                        r_grant_id <= w_gnt_id;
                    end
                end
                LOCK: begin
                    if (w_last_accept) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    // Registered write port: strobe follows an accept by one cycle, data
    // holds its last value when nothing is written.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            r_wr_en <= 1'b0;
            r_din   <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_din <= w_sel_data;
            end
        end
    end

    // Statistics counters; both wrap naturally at 2^CNT_WIDTH.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            r_pkt_cnt  <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (r_wr_en) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (w_last_accept) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            r_err_overflow <= 1'b0;
        end else if (fifo_overflow) begin
            r_err_overflow <= 1'b1;
        end
    end

    assign fifo_wr_en   = r_wr_en;
    assign fifo_din     = r_din;
    assign grant_id     = r_grant_id;
    assign busy         = (r_state != IDLE);
    assign pkt_cnt      = r_pkt_cnt;
    assign beat_cnt     = r_beat_cnt;
    assign err_overflow = r_err_overflow;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_nack_fifo_wr_arbiter.sv
// Directed bench for nack_fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=16,
// CNT_WIDTH=4). Requester beats carry {id, packet, beat} so the FIFO-side
// scoreboard shows grant order and contiguity.
module tb_nack_fifo_wr_arbiter;
    import nack_gen_pkg::*;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int CW = 4;

    logic             wr_clk;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_din;
    logic             fifo_full;
    logic             fifo_almost_full;
    logic             fifo_prog_full;
    logic             fifo_wr_rst_busy;
    logic             fifo_overflow;
    logic [1:0]       grant_id;
    logic             busy;
    logic [CW-1:0]    pkt_cnt;
    logic [CW-1:0]    beat_cnt;
    logic             err_overflow;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];

    int src_len    [NR];
    int src_budget [NR];
    int src_sent   [NR];
    int src_beat   [NR];
    int src_hold   [NR];

    logic [NR-1:0] r_acc;
    logic [NR-1:0] r_rdy;

    nack_fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .wr_clk           (wr_clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_din         (fifo_din),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_prog_full   (fifo_prog_full),
        .fifo_wr_rst_busy (fifo_wr_rst_busy),
        .fifo_overflow    (fifo_overflow),
        .grant_id         (grant_id),
        .busy             (busy),
        .pkt_cnt          (pkt_cnt),
        .beat_cnt         (beat_cnt),
        .err_overflow     (err_overflow),
        .dbg_state        (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_word(input int id, input int pkt, input int beat);
        return {4'(id), 4'(pkt), 8'(beat)};
    endfunction

    task automatic push_pkt(input int id, input int pkt, input int len);
        for (int b = 0; b < len; b++) exp_q.push_back(beat_word(id, pkt, b));
    endtask

    // Scoreboard: every FIFO write must match the next expected beat.
    always @(negedge wr_clk) begin
        if (fifo_wr_en === 1'b1) begin
            check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("wr_data", 32'(fifo_din), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive_srcs();
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = (src_sent[i] < src_budget[i]) && (src_hold[i] == 0);
            req_last[i]  = (src_beat[i] == src_len[i] - 1);
            req_data[i*DW +: DW] = beat_word(i, src_sent[i], src_beat[i]);
        end
    endtask

    // One clock: drive, sample handshake just before the edge, advance sources.
    task automatic step();
        drive_srcs();
        #1;
        r_acc = req_valid & req_ready;
        r_rdy = req_ready;
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (r_acc[i]) begin
                if (src_beat[i] == src_len[i] - 1) begin
                    src_beat[i] = 0;
                    src_sent[i] = src_sent[i] + 1;
                end else begin
                    src_beat[i] = src_beat[i] + 1;
                end
            end
            if (src_hold[i] > 0) src_hold[i] = src_hold[i] - 1;
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 1; src_budget[i] = 0; src_sent[i] = 0;
            src_beat[i] = 0; src_hold[i] = 0;
        end
    endtask

    task automatic do_reset();
        clear_srcs();
        fifo_full = 1'b0; fifo_almost_full = 1'b0; fifo_prog_full = 1'b0;
        fifo_wr_rst_busy = 1'b0; fifo_overflow = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) step();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'(INIT));
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
        check({tag, "_din"}, 32'(fifo_din), 32'd0);
        check({tag, "_grant"}, 32'(grant_id), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_pkt"}, 32'(pkt_cnt), 32'd0);
        check({tag, "_beat"}, 32'(beat_cnt), 32'd0);
        check({tag, "_err"}, 32'(err_overflow), 32'd0);
    endtask

    initial begin
        clear_srcs();
        req_valid = '0; req_data = '0; req_last = '0;
        fifo_full = 1'b0; fifo_almost_full = 1'b0; fifo_prog_full = 1'b0;
        fifo_overflow = 1'b0; fifo_wr_rst_busy = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge wr_clk);
        #1;
        rst = 1'b0;
        check_reset("rst");

        // Reset release with all requesters valid; continuous 3-beat packets.
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 3;
            src_budget[i] = (i == 0) ? 2 : 1;
        end
        for (int c = 0; c < 10; c++) begin
            step();
            check("busy_rdy", 32'(r_rdy), 32'd0);
            check("busy_wr_en", 32'(fifo_wr_en), 32'd0);
        end
        check("busy_state", 32'(dbg_state), 32'(INIT));
        fifo_wr_rst_busy = 1'b0;
        step();
        check("rel_idle", 32'(dbg_state), 32'(IDLE));
        check("rel_rdy", 32'(r_rdy), 32'd0);
        step();
        check("rel_lock", 32'(dbg_state), 32'(LOCK));
        check("rel_grant0", 32'(grant_id), 32'd0);
        push_pkt(0, 0, 3); push_pkt(1, 0, 3); push_pkt(2, 0, 3);
        push_pkt(3, 0, 3); push_pkt(0, 1, 3);
        repeat (15) step();
        check("fair_pkt4", 32'(pkt_cnt), 32'd4);
        check("fair_beat11", 32'(beat_cnt), 32'd11);
        check("fair_idle", 32'(dbg_state), 32'(IDLE));
        check("fair_last_gnt", 32'(grant_id), 32'd3);
        step();
        check("fair_beat12", 32'(beat_cnt), 32'd12);
        check("fair_wrap_gnt", 32'(grant_id), 32'd0);
        drain("fair_drain", 20);
        check("fair_pkt5", 32'(pkt_cnt), 32'd5);
        check("fair_beat15", 32'(beat_cnt), 32'd15);

        // Lock hold: requester 1 stalls mid-packet while 2 waits.
        do_reset();
        src_len[1] = 4; src_budget[1] = 1;
        push_pkt(1, 0, 4); push_pkt(2, 0, 2);
        step();
        step();
        check("hold_grant1", 32'(grant_id), 32'd1);
        src_len[2] = 2; src_budget[2] = 1;
        step();
        step();
        src_hold[1] = 5;
        for (int c = 0; c < 5; c++) begin
            step();
            check("hold_rdy", 32'(r_rdy), 32'b0010);
            check("hold_acc", 32'(r_acc), 32'd0);
            check("hold_grant", 32'(grant_id), 32'd1);
            check("hold_state", 32'(dbg_state), 32'(LOCK));
        end
        drain("hold_drain", 20);
        check("hold_pkt", 32'(pkt_cnt), 32'd2);

        // Backpressure: prog_full blocks new grants, almost_full stalls beats.
        do_reset();
        fifo_prog_full = 1'b1;
        src_len[0] = 4; src_budget[0] = 1;
        push_pkt(0, 0, 4); push_pkt(1, 0, 1);
        step();
        for (int c = 0; c < 3; c++) begin
            step();
            check("pf_idle", 32'(dbg_state), 32'(IDLE));
            check("pf_rdy", 32'(r_rdy), 32'd0);
        end
        fifo_prog_full = 1'b0;
        step();
        check("pf_lock", 32'(dbg_state), 32'(LOCK));
        fifo_prog_full = 1'b1;
        src_len[1] = 1; src_budget[1] = 1;
        step();
        check("af_pre_rdy", 32'(r_rdy), 32'b0001);
        fifo_almost_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("af_rdy", 32'(r_rdy), 32'd0);
        end
        fifo_almost_full = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("af_post_rdy", 32'(r_rdy), 32'b0001);
        end
        check("pf_done_idle", 32'(dbg_state), 32'(IDLE));
        for (int c = 0; c < 2; c++) begin
            step();
            check("pf_hold_idle", 32'(dbg_state), 32'(IDLE));
            check("pf_hold_rdy", 32'(r_rdy), 32'd0);
        end
        fifo_prog_full = 1'b0;
        drain("bp_drain", 10);
        check("bp_pkt", 32'(pkt_cnt), 32'd2);
        check("bp_beat", 32'(beat_cnt), 32'd5);

        // Counter wrap at CNT_WIDTH=4 and sticky overflow.
        do_reset();
        src_len[0] = 17; src_budget[0] = 1;
        push_pkt(0, 0, 17);
        drain("wrap_drain", 40);
        check("wrap_beat", 32'(beat_cnt), 32'd1);
        check("wrap_pkt", 32'(pkt_cnt), 32'd1);
        check("ovf_pre", 32'(err_overflow), 32'd0);
        fifo_overflow = 1'b1;
        step();
        fifo_overflow = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("ovf_sticky", 32'(err_overflow), 32'd1);
        end

        // Mid-packet reset on beat 2 of 4.
        do_reset();
        check("ovf_clr", 32'(err_overflow), 32'd0);
        src_len[0] = 4; src_budget[0] = 1;
        push_pkt(0, 0, 1);
        step();
        step();
        step();
        check("mid_wr_en", 32'(fifo_wr_en), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset("mid");
        clear_srcs();
        step();
        check("mid_exp_empty", 32'(exp_q.size()), 32'd0);
        check("mid_no_wr", 32'(fifo_wr_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
